// File: rtl/alu_pipelined_sparc_component.sv
// Registered SPARC8 ALU with valid/ready handshakes, icc register and optional shift-add UMUL.
// Define ALU_MUL_EN to build UMUL (op 16) and the Y register; otherwise op 16 is illegal and y is 0.
// Opcodes: 0 ADD 1 ADDX 2 SUB 3 SUBX 4 AND 5 ANDN 6 OR 7 ORN 8 XOR 9 XNOR
//          10 SLL 11 SRL 12 SRA 13 PASSA 14 PASSB 15 NOTB 16 UMUL, 17-31 illegal.
module alu_pipelined_sparc_component #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             cin,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       icc,
  output logic             op_err
);

  localparam int MSB = WIDTH - 1;

  logic             accept;
  logic             take;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       icc_q;
  logic             op_err_q;

  logic [WIDTH-1:0] res_d;
  logic             err_d;
  logic [3:0]       icc_d;
  logic             cc_upd;
  logic             v_flag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   cin_ext;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    res_d   = '0;
    err_d   = 1'b0;
    icc_d   = icc_q;
    cc_upd  = 1'b0;
    v_flag  = 1'b0;
    sum     = '0;
    cin_ext = {{WIDTH{1'b0}}, cin};
    case (op)
      5'd0:  sum = {1'b0, a} + {1'b0, b};
      5'd1:  sum = {1'b0, a} + {1'b0, b} + cin_ext;
      5'd2:  sum = {1'b0, a} - {1'b0, b};
      5'd3:  sum = {1'b0, a} - {1'b0, b} - cin_ext;
      5'd4:  res_d = a & b;
      5'd5:  res_d = a & ~b;
      5'd6:  res_d = a | b;
      5'd7:  res_d = a | ~b;
      5'd8:  res_d = a ^ b;
      5'd9:  res_d = ~(a ^ b);
      5'd10: res_d = a << b[SHW-1:0];
      5'd11: res_d = a >> b[SHW-1:0];
      5'd12: res_d = $signed(a) >>> b[SHW-1:0];
      5'd13: res_d = a;
      5'd14: res_d = b;
      5'd15: res_d = ~b;
`ifdef ALU_MUL_EN
      5'd16: res_d = '0;
`endif
      default: err_d = 1'b1;
    endcase

    // Sum bit WIDTH is carry for add and borrow for subtract.
    if (op < 5'd4) begin
      res_d  = sum[MSB:0];
      v_flag = op[1] ? ((a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]))
                     : ((a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]));
      icc_d  = {sum[MSB], sum[MSB:0] == '0, v_flag, sum[WIDTH]};
      cc_upd = 1'b1;
    end else if (op < 5'd10) begin
      icc_d  = {res_d[MSB], res_d == '0, 2'b00};
      cc_upd = 1'b1;
    end
  end

  assign take = out_valid_q && out_ready;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               cc_pend_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_nxt;

  // acc holds {partial product high word, remaining multiplier bits}.
  assign partial  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_nxt  = {partial, acc_q[MSB:1]};
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign y        = y_q;
`else
  assign in_ready = !out_valid_q || out_ready;
  assign y        = '0;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      icc_q       <= '0;
      op_err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cc_pend_q   <= 1'b0;
      y_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (take) out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      if (state_q == S_BUSY) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_q     <= S_IDLE;
          result_q    <= acc_nxt[MSB:0];
          y_q         <= acc_nxt[2*WIDTH-1:WIDTH];
          op_err_q    <= 1'b0;
          out_valid_q <= 1'b1;
          if (cc_pend_q) icc_q <= {acc_nxt[MSB], acc_nxt[MSB:0] == '0, 2'b00};
        end
      end else if (accept && (op == 5'd16)) begin
        state_q   <= S_BUSY;
        mcand_q   <= a;
        acc_q     <= {{WIDTH{1'b0}}, b};
        cnt_q     <= CNT_W'(WIDTH - 1);
        cc_pend_q <= set_cc;
      end else
`endif
      if (accept) begin
        result_q    <= res_d;
        op_err_q    <= err_d;
        out_valid_q <= 1'b1;
        if (set_cc && cc_upd) icc_q <= icc_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign icc       = icc_q;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_pipelined_sparc_component.sv
// Self-checking bench: directed vector table, backpressure/UMUL/reset sequences, random ops vs model.
module tb_alu_pipelined_sparc_component;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic [4:0]        op = '0;
  logic              cin = 1'b0;
  logic              set_cc = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  y;
  logic [3:0]        icc;
  logic              op_err;

  int n_checks = 0;
  int n_errors = 0;
  int busy_ready = 0;

  logic [3:0]  m_icc = '0;
  logic [31:0] m_y = '0;

  alu_pipelined_sparc_component #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .y(y),
    .icc(icc), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        cc;
    logic [31:0] res;
    logic        err;
    logic [3:0]  icc;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on wide integers, updates m_icc / m_y.
  task automatic model_step(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z,
                            input logic ci, input logic cc,
                            output logic [31:0] r, output logic e);
    longint unsigned ux, uz, ce, s;
    logic c, v;
    int kind;
    ux = x; uz = z; ce = 0; s = 0; c = 0; v = 0; kind = 0; r = '0; e = 1'b0;
    if (o <= 5'd3) begin
      if (o == 5'd1 || o == 5'd3) ce = ci;
      if (o < 5'd2) begin
        s = ux + uz + ce;
        r = s[31:0];
        c = s[32];
        v = (x[31] == z[31]) && (r[31] != x[31]);
      end else begin
        s = ux - uz - ce;
        r = s[31:0];
        c = ux < (uz + ce);
        v = (x[31] != z[31]) && (r[31] != x[31]);
      end
      kind = 1;
    end else begin
      case (o)
        5'd4:  begin r = x & z;     kind = 2; end
        5'd5:  begin r = x & ~z;    kind = 2; end
        5'd6:  begin r = x | z;     kind = 2; end
        5'd7:  begin r = x | ~z;    kind = 2; end
        5'd8:  begin r = x ^ z;     kind = 2; end
        5'd9:  begin r = ~(x ^ z);  kind = 2; end
        5'd10: r = x << z[4:0];
        5'd11: r = x >> z[4:0];
        5'd12: r = $signed(x) >>> z[4:0];
        5'd13: r = x;
        5'd14: r = z;
        5'd15: r = ~z;
`ifdef ALU_MUL_EN
        5'd16: begin
          s = ux * uz;
          r = s[31:0];
          m_y = s[63:32];
          kind = 2;
        end
`endif
        default: e = 1'b1;
      endcase
    end
    if (cc && kind == 1) m_icc = {r[31], r == 32'd0, v, c};
    if (cc && kind == 2) m_icc = {r[31], r == 32'd0, 2'b00};
  endtask

  // Issue one operation with out_ready=1 and return the delivered outputs and latency.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z,
                        input logic ci, input logic cc,
                        output logic [31:0] r, output logic e, output logic [3:0] f,
                        output logic [31:0] yv, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    op = o; a = x; b = z; cin = ci; set_cc = cc; in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    r = result; e = op_err; f = icc; yv = y;
  endtask

  initial begin
    logic [31:0] r, yv, er, hold;
    logic [3:0]  f;
    logic        e, ee;
    int          lat, seen;
    logic [4:0]  ro;

    vecs[0]  = '{5'd0,  32'h7FFFFFFF, 32'd1,        1'b0, 1'b1, 32'h80000000, 1'b0, 4'b1010};
    vecs[1]  = '{5'd2,  32'd0,        32'd1,        1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b1001};
    vecs[2]  = '{5'd4,  32'hF0,       32'h0F,       1'b0, 1'b0, 32'h0,        1'b0, 4'b1001};
    vecs[3]  = '{5'd12, 32'h80000000, 32'h24,       1'b0, 1'b1, 32'hF8000000, 1'b0, 4'b1001};
    vecs[4]  = '{5'd1,  32'hFFFFFFFF, 32'd0,        1'b1, 1'b1, 32'h0,        1'b0, 4'b0101};
    vecs[5]  = '{5'd3,  32'd5,        32'd3,        1'b1, 1'b1, 32'd1,        1'b0, 4'b0000};
    vecs[6]  = '{5'd9,  32'd0,        32'd0,        1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b1000};
    vecs[7]  = '{5'd10, 32'd1,        32'h1F,       1'b0, 1'b1, 32'h80000000, 1'b0, 4'b1000};
    vecs[8]  = '{5'd20, 32'd5,        32'd5,        1'b0, 1'b1, 32'h0,        1'b1, 4'b1000};
    vecs[9]  = '{5'd6,  32'd0,        32'd0,        1'b0, 1'b1, 32'h0,        1'b0, 4'b0100};
    vecs[10] = '{5'd11, 32'h80000000, 32'h21,       1'b0, 1'b0, 32'h40000000, 1'b0, 4'b0100};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_y", {32'd0, y}, 64'd0);
    check("rst_icc", {60'd0, icc}, 64'd0);
    check("rst_op_err", {63'd0, op_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].cc, r, e, f, yv, lat);
      model_step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].cc, er, ee);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd1);
      check($sformatf("vec%0d_res", i), {32'd0, r}, {32'd0, vecs[i].res});
      check($sformatf("vec%0d_err", i), {63'd0, e}, {63'd0, vecs[i].err});
      check($sformatf("vec%0d_icc", i), {60'd0, f}, {60'd0, vecs[i].icc});
    end

    // Backpressure: op A held, op B waits, then both move with no loss or duplication
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd2; cin = 1'b0; set_cc = 1'b0;
    @(negedge clk);
    check("bp_first_valid", {63'd0, out_valid}, 64'd1);
    check("bp_first_res", {32'd0, result}, 64'd3);
    a = 32'd10; b = 32'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("bp_hold_res_%0d", i), {32'd0, result}, 64'd3);
      check($sformatf("bp_hold_valid_%0d", i), {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_ready_on_take", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valid", {63'd0, out_valid}, 64'd1);
    check("bp_second_res", {32'd0, result}, 64'd30);
    @(negedge clk);
    check("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // UMUL corner case plus a few random multiplies
    busy_ready = 0;
    run_op(5'd16, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, r, e, f, yv, lat);
    model_step(5'd16, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, er, ee);
`ifdef ALU_MUL_EN
    check("umul_lat", 64'(lat), 64'd32);
    check("umul_res", {32'd0, r}, 64'hFFFFFFFE);
    check("umul_y", {32'd0, yv}, 64'd1);
    check("umul_err", {63'd0, e}, 64'd0);
    check("umul_icc", {60'd0, f}, 64'b1000);
    check("umul_busy_ready", 64'(busy_ready), 64'd0);
`else
    check("umul_off_lat", 64'(lat), 64'd1);
    check("umul_off_res", {32'd0, r}, 64'd0);
    check("umul_off_err", {63'd0, e}, 64'd1);
    check("umul_off_y", {32'd0, yv}, 64'd0);
    check("umul_off_icc", {60'd0, f}, {60'd0, m_icc});
`endif
    for (int i = 0; i < 4; i++) begin
      logic [31:0] x, z;
      logic        cc;
      x = $urandom; z = $urandom; cc = 1'($urandom_range(0, 1));
      run_op(5'd16, x, z, 1'b0, cc, r, e, f, yv, lat);
      model_step(5'd16, x, z, 1'b0, cc, er, ee);
      check($sformatf("rmul%0d_res", i), {32'd0, r}, {32'd0, er});
      check($sformatf("rmul%0d_err", i), {63'd0, e}, {63'd0, ee});
      check($sformatf("rmul%0d_y", i), {32'd0, yv}, {32'd0, m_y});
      check($sformatf("rmul%0d_icc", i), {60'd0, f}, {60'd0, m_icc});
    end

    // Random back-to-back single-cycle operations with out_ready=1
    @(negedge clk);
    ro = 5'($urandom_range(0, 30)); if (ro >= 5'd16) ro = ro + 5'd1;
    op = ro; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    set_cc = 1'($urandom_range(0, 1)); in_valid = 1'b1; out_ready = 1'b1;
    model_step(op, a, b, cin, set_cc, er, ee);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check($sformatf("rnd%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("rnd%0d_res", i), {32'd0, result}, {32'd0, er});
      check($sformatf("rnd%0d_err", i), {63'd0, op_err}, {63'd0, ee});
      check($sformatf("rnd%0d_icc", i), {60'd0, icc}, {60'd0, m_icc});
      check($sformatf("rnd%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      ro = 5'($urandom_range(0, 30)); if (ro >= 5'd16) ro = ro + 5'd1;
      op = ro; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      set_cc = 1'($urandom_range(0, 1));
      model_step(op, a, b, cin, set_cc, er, ee);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rnd_last_res", {32'd0, result}, {32'd0, er});
    check("rnd_last_icc", {60'd0, icc}, {60'd0, m_icc});

    // Reset in the middle of an operation (during BUSY when UMUL is built)
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; set_cc = 1'b1;
`ifdef ALU_MUL_EN
    op = 5'd16; a = 32'hFFFFFFFF; b = 32'd3;
`else
    op = 5'd0; a = 32'd3; b = 32'd4;
`endif
    @(negedge clk);
    in_valid = 1'b0;
`ifndef ALU_MUL_EN
    check("prerst_res", {32'd0, result}, 64'd7);
`endif
    repeat (9) @(negedge clk);
    hold = result;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_y", {32'd0, y}, 64'd0);
    check("midrst_icc", {60'd0, icc}, 64'd0);
    check("midrst_op_err", {63'd0, op_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("postrst_no_valid", 64'(seen), 64'd0);
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
